// File: rtl/bridge_pkg.sv
// Shared encodings and default timing for the bridge road-side sequencer.
package bridge_pkg;

  // Road sequencer state encoding
  localparam logic [1:0] StGreen   = 2'b00;
  localparam logic [1:0] StYellow  = 2'b01;
  localparam logic [1:0] StAllRed  = 2'b10;
  localparam logic [1:0] StStopped = 2'b11;

  // Default timing, all in clock cycles
  localparam int unsigned DEF_MIN_GREEN  = 5;
  localparam int unsigned DEF_YELLOW_CYC = 4;
  localparam int unsigned DEF_ALLRED_CYC = 3;
  localparam int unsigned DEF_BLINK_HALF = 2;

  // Largest of three timing values; sizes the shared phase counter
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/alarm_blinker.sv
// Registered blink generator: high on the first enabled edge, then toggles every HALF cycles.
module alarm_blinker #(
  parameter int unsigned HALF = 2
) (
  input  logic Clock,
  input  logic Reset,
  input  logic En,
  output logic Out
);

  localparam int unsigned W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [W-1:0] HalfLast = W'(HALF - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         out_q, out_d;
  // Distinguishes the very first enabled edge from a mid-blink low phase
  logic         active_q, active_d;

  // Next-state for the blink phase
  always_comb begin
    cnt_d    = '0;
    out_d    = 1'b0;
    active_d = 1'b0;
    if (En) begin
      active_d = 1'b1;
      if (!active_q) begin
        out_d = 1'b1;
      end else if (cnt_q == HalfLast) begin
        out_d = ~out_q;
      end else begin
        out_d = out_q;
        cnt_d = cnt_q + W'(1);
      end
    end
  end

  // Blink state registers with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt_q    <= '0;
      out_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      active_q <= active_d;
    end
  end

  assign Out = out_q;

endmodule

// File: rtl/bridge_traffic_sequencer.sv
// Road lamp / barrier sequencer driven by the drawbridge controller's TFL and AL requests.
module bridge_traffic_sequencer
  import bridge_pkg::*;
#(
  parameter int unsigned MIN_GREEN  = DEF_MIN_GREEN,
  parameter int unsigned YELLOW_CYC = DEF_YELLOW_CYC,
  parameter int unsigned ALLRED_CYC = DEF_ALLRED_CYC,
  parameter int unsigned BLINK_HALF = DEF_BLINK_HALF
) (
  input  logic Clock,
  input  logic Reset,
  input  logic TFL,
  input  logic AL,
  output logic GR,
  output logic YE,
  output logic RD,
  output logic Gate,
  output logic Buzz,
  output logic RoadClear
);

  localparam int unsigned CntW = $clog2(max3(MIN_GREEN, YELLOW_CYC, ALLRED_CYC) + 1);
  localparam logic [CntW-1:0] GreenLast  = CntW'(MIN_GREEN - 1);
  localparam logic [CntW-1:0] YellowLast = CntW'(YELLOW_CYC - 1);
  localparam logic [CntW-1:0] AllRedLast = CntW'(ALLRED_CYC - 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Next state and shared phase counter; counter clears on every state change
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StGreen: begin
        // Alarm skips the minimum-green hold
        if (AL || (TFL && (cnt_q == GreenLast))) begin
          state_d = StYellow;
          cnt_d   = '0;
        end else if (cnt_q != GreenLast) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StYellow: begin
        if (cnt_q == YellowLast) begin
          state_d = StAllRed;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StAllRed: begin
        if (cnt_q == AllRedLast) begin
          state_d = (TFL || AL) ? StStopped : StGreen;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStopped: begin
        if (!TFL && !AL) begin
          state_d = StGreen;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StGreen;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= StGreen;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore output decode from the state register only
  always_comb begin
    GR        = 1'b0;
    YE        = 1'b0;
    RD        = 1'b0;
    Gate      = 1'b0;
    RoadClear = 1'b0;
    unique case (state_q)
      StGreen:  GR = 1'b1;
      StYellow: YE = 1'b1;
      StAllRed: begin
        RD   = 1'b1;
        Gate = 1'b1;
      end
      StStopped: begin
        RD        = 1'b1;
        Gate      = 1'b1;
        RoadClear = 1'b1;
      end
      default: GR = 1'b1;
    endcase
  end

  alarm_blinker #(
    .HALF (BLINK_HALF)
  ) u_blinker (
    .Clock (Clock),
    .Reset (Reset),
    .En    (AL),
    .Out   (Buzz)
  );

endmodule

// File: tb/tb_bridge_traffic_sequencer.sv
// Self-checking bench: directed scenarios plus random TFL/AL/Reset against a timeline model.
module tb_bridge_traffic_sequencer;

  localparam int MG = 5;
  localparam int YC = 4;
  localparam int AR = 3;
  localparam int BH = 2;

  // Model phases (bench-local naming)
  localparam int M_GO    = 0;
  localparam int M_AMBER = 1;
  localparam int M_RED   = 2;
  localparam int M_HOLD  = 3;

  logic Clock = 1'b0;
  logic Reset, TFL, AL;
  logic GR, YE, RD, Gate, Buzz, RoadClear;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Model: phase, cycles spent in GREEN, cycles left in a timed phase, consecutive AL edges
  int m_mode    = M_GO;
  int m_elapsed = 0;
  int m_left    = 0;
  int m_alrun   = 0;

  bridge_traffic_sequencer dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .TFL       (TFL),
    .AL        (AL),
    .GR        (GR),
    .YE        (YE),
    .RD        (RD),
    .Gate      (Gate),
    .Buzz      (Buzz),
    .RoadClear (RoadClear)
  );

  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got {GR,YE,RD,Gate,Buzz,Clr}=%b expected %b at %0t", tag, got, exp,
               $time);
    end
  endtask

  function automatic logic [5:0] model_outs();
    logic buzz;
    buzz = (m_alrun > 0) && ((((m_alrun - 1) / BH) % 2) == 0);
    return {m_mode == M_GO, m_mode == M_AMBER, m_mode >= M_RED, m_mode >= M_RED, buzz,
            m_mode == M_HOLD};
  endfunction

  // Advance the model by one clock edge with the inputs seen at that edge
  task automatic model_edge(input logic rst, input logic tfl, input logic al);
    if (!rst) begin
      m_mode    = M_GO;
      m_elapsed = 0;
      m_alrun   = 0;
    end else begin
      m_alrun = al ? m_alrun + 1 : 0;
      case (m_mode)
        M_GO: begin
          if (al || (tfl && m_elapsed >= MG - 1)) begin
            m_mode = M_AMBER;
            m_left = YC;
          end else begin
            m_elapsed++;
          end
        end
        M_AMBER: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_RED;
            m_left = AR;
          end
        end
        M_RED: begin
          m_left--;
          if (m_left == 0) begin
            m_mode    = (tfl || al) ? M_HOLD : M_GO;
            m_elapsed = 0;
          end
        end
        default: begin
          if (!tfl && !al) begin
            m_mode    = M_GO;
            m_elapsed = 0;
          end
        end
      endcase
    end
  endtask

  task automatic step(input logic rst, input logic tfl, input logic al, input string tag);
    Reset = rst;
    TFL   = tfl;
    AL    = al;
    @(posedge Clock);
    model_edge(rst, tfl, al);
    #1;
    check_eq(tag, {GR, YE, RD, Gate, Buzz, RoadClear}, model_outs());
  endtask

  initial begin
    int guard;
    logic r, t, a;

    // 1: reset with TFL high, then full stop sequence
    step(1'b0, 1'b1, 1'b0, "t1_reset");
    step(1'b0, 1'b1, 1'b0, "t1_reset");
    check_eq("t1_reset_const", {GR, YE, RD, Gate, Buzz, RoadClear}, 6'b100000);
    for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0, "t1_stop_seq");
    check_eq("t1_stopped_const", {GR, YE, RD, Gate, Buzz, RoadClear}, 6'b001101);

    // 2: release from STOPPED, minimum green restarts
    step(1'b1, 1'b0, 1'b0, "t2_release");
    check_eq("t2_green_const", {GR, YE, RD, Gate, Buzz, RoadClear}, 6'b100000);
    for (int i = 0; i < 13; i++) step(1'b1, 1'b1, 1'b0, "t2_min_green");

    // 3: drop TFL in the first ALL_RED cycle
    step(1'b1, 1'b0, 1'b0, "t3_release");
    guard = 0;
    while (m_mode != M_RED && guard < 20) begin
      step(1'b1, 1'b1, 1'b0, "t3_approach");
      guard++;
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, "t3_allred_drop");

    // 4: alarm in the first GREEN cycle after reset
    step(1'b0, 1'b0, 1'b0, "t4_reset");
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, "t4_alarm");
    step(1'b1, 1'b0, 1'b0, "t4_clear");
    step(1'b1, 1'b0, 1'b0, "t4_clear");

    // 5: reset while STOPPED with alarm active
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, "t5_to_stop");
    step(1'b0, 1'b1, 1'b1, "t5_reset");
    check_eq("t5_reset_const", {GR, YE, RD, Gate, Buzz, RoadClear}, 6'b100000);

    // 6: TFL pulse during YELLOW has no effect
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, "t6_green");
    step(1'b1, 1'b1, 1'b0, "t6_pulse_go");
    step(1'b1, 1'b0, 1'b0, "t6_yellow");
    step(1'b1, 1'b1, 1'b0, "t6_yellow_pulse");
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, "t6_finish");

    // Random traffic: sticky TFL/AL with occasional toggles and rare resets
    t = 1'b0;
    a = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 11) == 0) t = ~t;
      if ($urandom_range(0, 29) == 0) a = ~a;
      step(r, t, a, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bridge_traffic_sequencer.md
# bridge_traffic_sequencer

Road-side signal sequencer that sits directly downstream of the drawbridge controller. It consumes the controller's traffic-light request (TFL) and alarm (AL) outputs and drives the physical road lamps, barrier gate and buzzer. It enforces green → yellow → all-red timing before reporting the road clear. Moore state machine plus one blink sub-module; all timing is counted in Clock cycles.

## Interface
- MIN_GREEN, 5, minimum cycles spent in GREEN before a TFL request is honoured (≥1)
- YELLOW_CYC, 4, exact cycles spent in YELLOW (≥1)
- ALLRED_CYC, 3, exact cycles spent in ALL_RED before the road is declared clear (≥1)
- BLINK_HALF, 2, buzzer half-period in cycles (≥1)
- Clock  in  1  single system clock; all state updates on its rising edge
- Reset  in  1  synchronous, active-low reset
- TFL  in  1  stop-traffic request from the bridge controller (1 = stop)
- AL  in  1  alarm from the bridge controller (1 = fault)
- GR, YE, RD  out  1 each  green, yellow and red road lamps; exactly one is high at all times
- Gate  out  1  barrier (1 = down)
- Buzz  out  1  audible alarm drive
- RoadClear  out  1  road is stopped and the gate is down; safe to move the bridge

## Operation
- States: GREEN, YELLOW, ALL_RED, STOPPED; one shared cycle counter `cnt`, cleared on every state change.
- GREEN: GR=1. `cnt` counts up and saturates at MIN_GREEN−1.
  - Go to YELLOW if AL=1, or if TFL=1 and `cnt`==MIN_GREEN−1.
  - AL bypasses the minimum-green time.
- YELLOW: YE=1. Lasts exactly YELLOW_CYC cycles, then goes to ALL_RED. Cannot be aborted.
- ALL_RED: RD=1, Gate=1. Lasts exactly ALLRED_CYC cycles.
  - On the last cycle, go to STOPPED if TFL=1 or AL=1; otherwise go to GREEN.
- STOPPED: RD=1, Gate=1, RoadClear=1. Go to GREEN when TFL=0 and AL=0, sampled on the same edge.
- Lamp, Gate and RoadClear outputs are decoded from the state register only (Moore, no input-to-output path).
- Buzz:
  - While AL=1, Buzz is registered and toggles every BLINK_HALF cycles.
  - It goes high on the first edge at which AL is sampled 1.
  - On the first edge with AL=0, Buzz goes to 0 and the blink counter clears.
- Counter width: $clog2 of max(MIN_GREEN, YELLOW_CYC, ALLRED_CYC)+1. No wrap is possible because every count terminates or saturates.
- Reset (Reset=0 at an edge, any state, mid-sequence included):
  - state GREEN, `cnt`=0, blink counter 0.
  - GR=1, YE=0, RD=0, Gate=0, Buzz=0, RoadClear=0.
  - Reset has priority over all inputs.

## Timing
- TFL rising in GREEN after the minimum time: YE=1 after the next edge.
- Full stop latency from that point: YELLOW_CYC + ALLRED_CYC cycles until RoadClear=1. Defaults: 7 cycles.
- TFL falling in STOPPED: GR=1, Gate=0 and RoadClear=0 after the next edge. The minimum-green time restarts.
- A single-cycle TFL pulse in GREEN, after the minimum time, runs the full YELLOW and ALL_RED sequence, then returns to GREEN.
- TFL and AL both rising on the same edge in GREEN: transition to YELLOW; Buzz goes high on the same edge.

## Structure
- Shared package bridge_pkg holds:
  - the 2-bit state encoding: GREEN=00, YELLOW=01, ALL_RED=10, STOPPED=11;
  - default timing constants DEF_MIN_GREEN, DEF_YELLOW_CYC, DEF_ALLRED_CYC, DEF_BLINK_HALF.
- Sub-module alarm_blinker (Clock, Reset, En, Out; parameter HALF) generates Buzz. The state machine and counter stay in the top-level module.

## Test plan
Defaults are used throughout.
1. Reset for 2 cycles with TFL=1, then release with TFL held at 1 → GR=1 for 5 cycles, YE=1 for 4, RD=Gate=1 for 3, then RoadClear=1 stays high.
2. From STOPPED, drop TFL → next edge GR=1, Gate=0, RoadClear=0. Re-raise TFL immediately → YE rises only after 5 GREEN cycles.
3. Drop TFL in the first ALL_RED cycle → ALL_RED still lasts 3 cycles, then GREEN. RoadClear is never 1.
4. Raise AL with TFL=0 in the first GREEN cycle after reset → YE next edge. Buzz pattern is 1,1,0,0,1,1. The sequence holds in STOPPED until AL=0, after which Buzz=0 and GR=1 on the next edge.
5. Assert Reset while in STOPPED with AL=1 → next edge GR=1, Gate=0, RoadClear=0, Buzz=0.
6. Pulse TFL for 1 cycle during YELLOW → the sequence is unaffected: 4 YE cycles, 3 ALL_RED cycles, then GREEN.
